// File: rtl/usb_ahb_pkg.sv
// Shared types and AHB encodings for the USB endpoint AHB initiator.
// Command and response bundles travel between the host side and the bus side.
package usb_ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic [1:0] HSIZE_BYTE = 2'b00;
   localparam logic [1:0] HSIZE_HALF = 2'b01;
   localparam logic [1:0] HSIZE_WORD = 2'b10;

   typedef struct packed {
      logic        write;
      logic [3:0]  addr;
      logic [1:0]  size;
      logic [31:0] wdata;
   } ahb_cmd_t;

   typedef struct packed {
      logic        write;
      logic [31:0] rdata;
      logic        error;
   } ahb_rsp_t;

endpackage

// File: rtl/ahb_wait_timer.sv
// Saturating data-phase wait-state counter with a sticky timeout flag.
// A limit of zero disables the flag; the transfer itself is never aborted.
module ahb_wait_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic i_rst,
   input  logic i_wait,
   input  logic i_clear,
   output logic o_timeout
);

   localparam int unsigned CW =
      (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_next;
   logic          r_timeout;
   logic          w_hit;

   assign w_next = (&r_cnt) ? r_cnt : r_cnt + CW'(1);

   // Flag rises on the same edge the count reaches the limit.
   assign w_hit = (TIMEOUT_CYCLES != 0) && i_wait
                  && (32'(w_next) >= TIMEOUT_CYCLES);

   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (i_clear)
            r_cnt <= '0;
         else if (i_wait)
            r_cnt <= w_next;
         if (w_hit)
            r_timeout <= 1'b1;
      end
   end

   assign o_timeout = r_timeout;

endmodule

// File: rtl/usb_ahb_master.sv
// AHB-Lite initiator for the USB endpoint slave port.
// Address slot A overlaps data slot D so back-to-back commands issue every cycle.
module usb_ahb_master
   import usb_ahb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [3:0]  cmd_addr,
   input  logic [1:0]  cmd_size,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   output logic        rsp_write,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error,
   output logic        hsel,
   output logic [3:0]  haddr,
   output logic [1:0]  hsize,
   output logic [1:0]  htrans,
   output logic        hwrite,
   output logic [31:0] hwdata,
   input  logic [31:0] hrdata,
   input  logic        hready,
   input  logic        hresp,
   output logic        busy,
   output logic        bus_timeout
);

   ahb_cmd_t    r_a;
   logic        r_a_valid;
   logic        r_d_valid;
   logic        r_d_write;
   logic [31:0] r_d_wdata;
   ahb_rsp_t    r_rsp;
   logic        r_rsp_valid;

   logic        w_nonseq;
   logic        w_accept_a;
   logic        w_complete_d;
   logic        w_cmd_acc;
   logic        w_wait;

   // An ERROR response forces IDLE so the pending address is replayed.
   assign w_nonseq     = r_a_valid && !(r_d_valid && hresp);
   assign w_accept_a   = w_nonseq && hready;
   assign w_complete_d = r_d_valid && hready;
   assign w_wait       = r_d_valid && !hready;

   assign cmd_ready = !n_rst && (!r_a_valid || w_accept_a);
   assign w_cmd_acc = cmd_valid && cmd_ready;

   always_ff @(posedge clk) begin
      if (n_rst) begin
         r_a         <= '0;
         r_a_valid   <= 1'b0;
         r_d_valid   <= 1'b0;
         r_d_write   <= 1'b0;
         r_d_wdata   <= '0;
         r_rsp       <= '0;
         r_rsp_valid <= 1'b0;
      end else begin
         if (w_accept_a) begin
            r_d_valid <= 1'b1;
            r_d_write <= r_a.write;
            r_d_wdata <= r_a.wdata;
         end else if (w_complete_d) begin
            r_d_valid <= 1'b0;
         end

         if (w_cmd_acc) begin
            r_a_valid <= 1'b1;
            r_a       <= '{write: cmd_write, addr: cmd_addr,
                           size: cmd_size, wdata: cmd_wdata};
         end else if (w_accept_a) begin
            r_a_valid <= 1'b0;
         end

         r_rsp_valid <= w_complete_d;
         if (w_complete_d)
            r_rsp <= '{write: r_d_write,
                       rdata: r_d_write ? 32'h0 : hrdata,
                       error: hresp};
         else
            r_rsp <= '0;
      end
   end

   ahb_wait_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk       (clk),
      .i_rst     (n_rst),
      .i_wait    (w_wait),
      .i_clear   (w_complete_d),
      .o_timeout (bus_timeout)
   );

   assign hsel   = r_a_valid;
   assign haddr  = r_a.addr;
   assign hsize  = r_a.size;
   assign hwrite = r_a.write;
   assign htrans = w_nonseq ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign hwdata = r_d_wdata;

   assign rsp_valid = r_rsp_valid;
   assign rsp_write = r_rsp.write;
   assign rsp_rdata = r_rsp.rdata;
   assign rsp_error = r_rsp.error;

   assign busy = r_a_valid || r_d_valid;

endmodule

// File: tb/tb_usb_ahb_master.sv
// Self-checking bench: cycle tables, timeout/reset sequences, and random
// traffic against a memory-backed slave with an in-order response model.
module tb_usb_ahb_master;
   import usb_ahb_pkg::*;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [3:0]  cmd_addr;
   logic [1:0]  cmd_size;
   logic [31:0] cmd_wdata;
   logic        rsp_valid, rsp_write, rsp_error;
   logic [31:0] rsp_rdata;
   logic        hsel, hwrite;
   logic [3:0]  haddr;
   logic [1:0]  hsize, htrans;
   logic [31:0] hwdata, hrdata;
   logic        hready, hresp, busy, bus_timeout;

   usb_ahb_master #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .n_rst(n_rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr),
      .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
      .hsel(hsel), .haddr(haddr), .hsize(hsize), .htrans(htrans),
      .hwrite(hwrite), .hwdata(hwdata), .hrdata(hrdata),
      .hready(hready), .hresp(hresp),
      .busy(busy), .bus_timeout(bus_timeout)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // cycle vector: inputs then expected outputs
   typedef struct {
      logic [31:0] cv, cw, ca, cs, cd, hr, hp, rd;
      logic [31:0] rdy, hs, tr, ad, hw, sz, wdc, wd;
      logic [31:0] rv, rw, rdat, re, bsy;
   } vec_t;
   vec_t tbl[$];

   // slave model (random phase)
   logic        auto_en = 1'b0;
   logic [31:0] smem[16];
   logic [31:0] rmem[16];
   logic        s_hsel, s_hw, s_hr;
   logic [1:0]  s_tr;
   logic [3:0]  s_ad;
   logic [31:0] s_wd;
   logic        dp_act = 1'b0, dp_w = 1'b0, dp_err = 1'b0, dp_ph2 = 1'b0;
   logic [3:0]  dp_a = 4'h0;
   int          dp_wait = 0;

   always begin
      @(negedge clk);
      s_hsel = hsel; s_tr = htrans; s_ad = haddr;
      s_hw = hwrite; s_wd = hwdata; s_hr = hready;
      @(posedge clk);
      #1;
      if (auto_en) begin
         if (dp_act && s_hr) begin
            if (dp_w && !dp_err) smem[dp_a] = s_wd;
            dp_act = 1'b0;
         end else if (dp_act) begin
            if (dp_wait != 0) dp_wait--;
            else if (dp_err) dp_ph2 = 1'b1;
         end
         if (s_hsel && s_tr == 2'b10 && s_hr) begin
            dp_act = 1'b1; dp_a = s_ad; dp_w = s_hw;
            dp_err = (s_ad == 4'hF); dp_ph2 = 1'b0;
            dp_wait = $urandom_range(0, 3);
         end
         if (!dp_act) begin
            hready = 1'b1; hresp = 1'b0; hrdata = $urandom;
         end else if (dp_wait != 0) begin
            hready = 1'b0; hresp = 1'b0; hrdata = $urandom;
         end else if (dp_err) begin
            hready = dp_ph2; hresp = 1'b1; hrdata = 32'h0;
         end else begin
            hready = 1'b1; hresp = 1'b0;
            hrdata = dp_w ? $urandom : smem[dp_a];
         end
      end
   end

   ahb_cmd_t q[$];

   task automatic sb_sample;
      ahb_cmd_t c;
      logic     err;
      logic [31:0] exp_rd;
      if (cmd_valid && cmd_ready)
         q.push_back('{write: cmd_write, addr: cmd_addr,
                       size: cmd_size, wdata: cmd_wdata});
      if (rsp_valid) begin
         chk("rsp_has_cmd", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) begin
            c = q.pop_front();
            err = (c.addr == 4'hF);
            exp_rd = 32'h0;
            if (c.write) begin
               if (!err) rmem[c.addr] = c.wdata;
            end else if (!err) begin
               exp_rd = rmem[c.addr];
            end
            chk("rnd_write", 32'(rsp_write), 32'(c.write));
            chk("rnd_rdata", rsp_rdata, exp_rd);
            chk("rnd_error", 32'(rsp_error), 32'(err));
         end
      end
   endtask

   task automatic drive_cmd(input logic v, input logic w, input logic [3:0] a,
                            input logic [1:0] s, input logic [31:0] d);
      cmd_valid = v; cmd_write = w; cmd_addr = a;
      cmd_size = s; cmd_wdata = d;
   endtask

   initial begin
      vec_t v;
      //           cv cw ca   cs cd            hr hp rd
      //           rdy hs tr ad  hw sz wdc wd  rv rw rdat re bsy
      tbl.push_back('{1,1,4'h4,2,32'hDEADBEEF,1,0,0, 1,0,0,0,0,0,0,0, 0,0,0,0,0});
      tbl.push_back('{0,0,0,0,0,1,0,0, 1,1,2,4'h4,1,2,0,0, 0,0,0,0,1});
      tbl.push_back('{0,0,0,0,0,1,0,0, 1,0,0,0,0,0,1,32'hDEADBEEF, 0,0,0,0,1});
      tbl.push_back('{0,0,0,0,0,1,0,0, 1,0,0,0,0,0,0,0, 1,1,0,0,0});
      tbl.push_back('{1,0,4'h8,2,0,1,0,0, 1,0,0,0,0,0,0,0, 0,0,0,0,0});
      tbl.push_back('{1,1,4'hC,0,32'h12345678,1,0,0, 1,1,2,4'h8,0,2,0,0, 0,0,0,0,1});
      tbl.push_back('{0,0,0,0,0,1,0,32'hA5, 1,1,2,4'hC,1,0,0,0, 0,0,0,0,1});
      tbl.push_back('{0,0,0,0,0,1,0,0, 1,0,0,0,0,0,1,32'h12345678, 1,0,32'hA5,0,1});
      tbl.push_back('{0,0,0,0,0,1,0,0, 1,0,0,0,0,0,0,0, 1,1,0,0,0});
      tbl.push_back('{1,1,4'h0,2,32'h11111111,1,0,0, 1,0,0,0,0,0,0,0, 0,0,0,0,0});
      tbl.push_back('{1,0,4'h2,1,0,1,0,0, 1,1,2,4'h0,1,2,0,0, 0,0,0,0,1});
      for (int i = 0; i < 3; i++)
         tbl.push_back('{0,0,0,0,0,0,0,0, 0,1,2,4'h2,0,1,1,32'h11111111, 0,0,0,0,1});
      tbl.push_back('{0,0,0,0,0,1,0,32'h5A5A, 1,1,2,4'h2,0,1,1,32'h11111111, 0,0,0,0,1});
      tbl.push_back('{0,0,0,0,0,1,0,32'h77, 1,0,0,0,0,0,0,0, 1,1,0,0,1});
      tbl.push_back('{0,0,0,0,0,1,0,0, 1,0,0,0,0,0,0,0, 1,0,32'h77,0,0});
      tbl.push_back('{1,0,4'h6,2,0,1,0,0, 1,0,0,0,0,0,0,0, 0,0,0,0,0});
      tbl.push_back('{1,1,4'hA,2,32'hCAFEF00D,1,0,0, 1,1,2,4'h6,0,2,0,0, 0,0,0,0,1});
      tbl.push_back('{0,0,0,0,0,0,1,0, 0,1,0,4'hA,1,2,0,0, 0,0,0,0,1});
      tbl.push_back('{0,0,0,0,0,1,1,0, 0,1,0,4'hA,1,2,0,0, 0,0,0,0,1});
      tbl.push_back('{0,0,0,0,0,1,0,0, 1,1,2,4'hA,1,2,0,0, 1,0,0,1,1});
      tbl.push_back('{0,0,0,0,0,1,0,0, 1,0,0,0,0,0,1,32'hCAFEF00D, 0,0,0,0,1});
      tbl.push_back('{0,0,0,0,0,1,0,0, 1,0,0,0,0,0,0,0, 1,1,0,0,0});
      tbl.push_back('{1,0,4'h3,2,0,1,1,0, 1,0,0,0,0,0,0,0, 0,0,0,0,0});
      tbl.push_back('{0,0,0,0,0,1,1,0, 1,1,2,4'h3,0,2,0,0, 0,0,0,0,1});
      tbl.push_back('{0,0,0,0,0,1,0,32'h9, 1,0,0,0,0,0,0,0, 0,0,0,0,1});
      tbl.push_back('{0,0,0,0,0,1,0,0, 1,0,0,0,0,0,0,0, 1,0,32'h9,0,0});

      for (int i = 0; i < 16; i++) begin
         smem[i] = $urandom;
         rmem[i] = smem[i];
      end

      // reset
      n_rst = 1'b1;
      drive_cmd(1'b0, 1'b0, 4'h0, 2'b00, 32'h0);
      hready = 1'b1; hresp = 1'b0; hrdata = 32'h0;
      step(); step();
      chk("rst_cmd_ready", 32'(cmd_ready), 0);
      chk("rst_htrans", 32'(htrans), 0);
      chk("rst_hsel", 32'(hsel), 0);
      chk("rst_haddr", 32'(haddr), 0);
      chk("rst_hsize", 32'(hsize), 0);
      chk("rst_hwrite", 32'(hwrite), 0);
      chk("rst_hwdata", hwdata, 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_timeout", 32'(bus_timeout), 0);
      n_rst = 1'b0;

      // cycle tables
      for (int k = 0; k < tbl.size(); k++) begin
         v = tbl[k];
         drive_cmd(v.cv[0], v.cw[0], v.ca[3:0], v.cs[1:0], v.cd);
         hready = v.hr[0]; hresp = v.hp[0]; hrdata = v.rd;
         @(negedge clk);
         chk($sformatf("r%0d_cmd_ready", k), 32'(cmd_ready), v.rdy);
         chk($sformatf("r%0d_hsel", k), 32'(hsel), v.hs);
         chk($sformatf("r%0d_htrans", k), 32'(htrans), v.tr);
         if (v.hs[0]) begin
            chk($sformatf("r%0d_haddr", k), 32'(haddr), v.ad);
            chk($sformatf("r%0d_hwrite", k), 32'(hwrite), v.hw);
            chk($sformatf("r%0d_hsize", k), 32'(hsize), v.sz);
         end
         if (v.wdc[0])
            chk($sformatf("r%0d_hwdata", k), hwdata, v.wd);
         chk($sformatf("r%0d_rsp_valid", k), 32'(rsp_valid), v.rv);
         if (v.rv[0]) begin
            chk($sformatf("r%0d_rsp_write", k), 32'(rsp_write), v.rw);
            chk($sformatf("r%0d_rsp_rdata", k), rsp_rdata, v.rdat);
            chk($sformatf("r%0d_rsp_error", k), 32'(rsp_error), v.re);
         end
         chk($sformatf("r%0d_busy", k), 32'(busy), v.bsy);
         chk($sformatf("r%0d_timeout", k), 32'(bus_timeout), 0);
         step();
      end

      // random traffic with memory slave
      drive_cmd(1'b0, 1'b0, 4'h0, 2'b00, 32'h0);
      hready = 1'b1; hresp = 1'b0;
      auto_en = 1'b1;
      step(); step();
      for (int c = 0; c < 400; c++) begin
         drive_cmd(($urandom_range(0, 3) != 0), 1'($urandom),
                   4'($urandom), 2'($urandom_range(0, 2)), $urandom);
         @(negedge clk);
         sb_sample();
         step();
      end
      drive_cmd(1'b0, 1'b0, 4'h0, 2'b00, 32'h0);
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         sb_sample();
         step();
      end
      chk("rnd_drained", 32'(q.size()), 0);
      chk("rnd_timeout", 32'(bus_timeout), 0);
      auto_en = 1'b0;
      hready = 1'b1; hresp = 1'b0; hrdata = 32'h0;
      step();

      // timeout after 8 wait states
      drive_cmd(1'b1, 1'b1, 4'h1, 2'b10, 32'h55);
      step();
      drive_cmd(1'b0, 1'b0, 4'h0, 2'b00, 32'h0);
      step();
      hready = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         step();
         chk($sformatf("to_wait%0d", i), 32'(bus_timeout), 32'(i >= 8));
      end
      hready = 1'b1;
      step();
      chk("to_rsp_valid", 32'(rsp_valid), 1);
      chk("to_sticky", 32'(bus_timeout), 1);
      step();
      chk("to_sticky_idle", 32'(bus_timeout), 1);
      chk("to_idle_busy", 32'(busy), 0);
      n_rst = 1'b1;
      drive_cmd(1'b1, 1'b0, 4'h2, 2'b10, 32'h0);
      #1;
      chk("rst_blocks_ready", 32'(cmd_ready), 0);
      step();
      n_rst = 1'b0;
      drive_cmd(1'b0, 1'b0, 4'h0, 2'b00, 32'h0);
      chk("to_cleared", 32'(bus_timeout), 0);
      chk("to_rst_busy", 32'(busy), 0);

      // reset in the middle of a data phase
      drive_cmd(1'b1, 1'b1, 4'h5, 2'b10, 32'hA5A5A5A5);
      step();
      drive_cmd(1'b0, 1'b0, 4'h0, 2'b00, 32'h0);
      step();
      hready = 1'b0;
      step();
      chk("mid_busy_pre", 32'(busy), 1);
      n_rst = 1'b1;
      step();
      n_rst = 1'b0;
      chk("mid_htrans", 32'(htrans), 0);
      chk("mid_busy", 32'(busy), 0);
      chk("mid_hsel", 32'(hsel), 0);
      chk("mid_hwdata", hwdata, 0);
      chk("mid_rsp_valid", 32'(rsp_valid), 0);
      hready = 1'b1;
      step();
      chk("mid_no_rsp", 32'(rsp_valid), 0);
      drive_cmd(1'b1, 1'b0, 4'h7, 2'b10, 32'h0);
      step();
      drive_cmd(1'b0, 1'b0, 4'h0, 2'b00, 32'h0);
      step();
      hrdata = 32'h0000BEEF;
      step();
      chk("post_rsp_valid", 32'(rsp_valid), 1);
      chk("post_rsp_write", 32'(rsp_write), 0);
      chk("post_rsp_rdata", rsp_rdata, 32'h0000BEEF);
      chk("post_rsp_error", 32'(rsp_error), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/usb_ahb_master.md
Name: usb_ahb_master

Overview:
- AHB-Lite initiator that drives the USB endpoint's AHB slave port (hsel/haddr/htrans/hsize/hwrite/hwdata out; hrdata/hready/hresp in).
- Accepts single-beat commands on a valid/ready interface and issues pipelined NONSEQ transfers, overlapping each address phase with the previous data phase.
- Returns one response per command, carrying read data and error status.
- Used by the bench/host-side controller to load TX data, read RX data and poll endpoint status.

Parameters:
TIMEOUT_CYCLES, 16, consecutive data-phase wait states before bus_timeout sets; 0 disables the check.

Ports:
clk  in  1  system clock; all logic on rising edge
n_rst  in  1  one clock; reset is synchronous and active-high
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted on cycles where cmd_valid&&cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  4  register address
cmd_size  in  2  hsize encoding (byte/half/word)
cmd_wdata  in  32  write data
rsp_valid  out  1  one-cycle response pulse; no backpressure
rsp_write  out  1  response belongs to a write
rsp_rdata  out  32  read data; 0 for writes
rsp_error  out  1  slave returned ERROR
hsel  out  1  slave select
haddr  out  4  AHB address
hsize  out  2  AHB size
htrans  out  2  IDLE=2'b00, NONSEQ=2'b10 only
hwrite  out  1  AHB write
hwdata  out  32  write data, data phase
hrdata  in  32  read data
hready  in  1  slave ready
hresp  in  1  slave error
busy  out  1  any transfer in flight
bus_timeout  out  1  sticky timeout flag

Behaviour:
- Two internal slots:
  - A (address phase): a_valid, addr, size, write, wdata.
  - D (data phase): d_valid, write, wdata.
- hsel=a_valid. haddr/hsize/hwrite come from slot A. hwdata=D.wdata.
- htrans=NONSEQ when a_valid && !(d_valid && hresp); otherwise IDLE.
- accept_a = a_valid && htrans==NONSEQ && hready.
  - On accept_a: D<=A, d_valid<=1.
- complete_d = d_valid && hready.
  - On complete_d && !accept_a: d_valid<=0.
- cmd_ready = !a_valid || accept_a. This is combinational from hready.
  - Command accept loads A. Otherwise, accept_a clears a_valid.
- Address/control outputs stay stable while a_valid && !accept_a.
- Response is registered, 1 cycle after complete_d:
  - rsp_valid=1.
  - rsp_write=D.write.
  - rsp_rdata=hrdata for reads, 0 for writes.
  - rsp_error=hresp.
- Zero-wait latency: command accepted at edge N → address phase cycle N+1 → data phase N+2 → rsp_valid cycle N+3.
- Back-to-back zero-wait commands sustain one transfer per cycle.
- Wait states (d_valid, hready=0): A and D are held, cmd_ready=0 if a_valid, no response.
- Error, two-cycle AHB response:
  - Cycle 1: hresp=1, hready=0. Cycle 2: hresp=1, hready=1.
  - htrans is forced IDLE in both cycles, so a pending A is not accepted.
  - Cycle 2 completes D with rsp_error=1.
  - A is re-presented as NONSEQ the following cycle; no command is dropped.
- hresp=1 with d_valid=0 is ignored.
- Timeout:
  - wait_cnt increments on d_valid && !hready, saturates, and clears on complete_d.
  - When wait_cnt reaches TIMEOUT_CYCLES (nonzero), bus_timeout<=1 and stays set until reset.
  - The transfer is not aborted.
- busy = a_valid || d_valid.
- Reset (n_rst=1 sampled at an edge):
  - After that edge: a_valid=d_valid=0, htrans=IDLE, hsel=0, haddr=0, hsize=0, hwrite=0, hwdata=0.
  - Also: rsp_valid=0, rsp_*=0, busy=0, bus_timeout=0, wait_cnt=0.
  - cmd_ready=0 while n_rst=1.
  - In-flight transfers produce no response.

Decomposition:
- Shared package usb_ahb_pkg:
  - HTRANS_IDLE/HTRANS_NONSEQ.
  - HSIZE_BYTE/HALF/WORD.
  - ahb_cmd_t struct (write, addr, size, wdata).
  - ahb_rsp_t struct (write, rdata, error).
- One natural sub-module: ahb_wait_timer (saturating wait counter plus sticky timeout flag).

Test Plan:
1. Write addr 4'h4, wdata 32'hDEADBEEF, hready=1 → next cycle: htrans=2'b10, haddr=4'h4, hwrite=1, hsel=1. Following cycle: hwdata=32'hDEADBEEF, htrans=IDLE. Then rsp_valid=1, rsp_write=1, rsp_error=0.
2. Back-to-back read 4'h8 then write 4'hC, zero wait, slave hrdata=32'h000000A5 → NONSEQ on two consecutive cycles, cmd_ready stays 1, two consecutive rsp_valid pulses, first rsp_rdata=32'h000000A5.
3. Data phase with hready low 3 cycles and a second command pending → haddr/htrans held NONSEQ, cmd_ready=0, busy=1. rsp_valid exactly 1 cycle after hready returns.
4. Read, then hresp=1/hready=0 followed by hresp=1/hready=1, with a write pending → htrans IDLE both cycles, rsp_error=1. Pending write re-issued next cycle and completes with rsp_error=0.
5. TIMEOUT_CYCLES=8, hready low 8 consecutive data-phase cycles → bus_timeout=1 after the 8th. It remains 1 after the transfer completes and clears only on n_rst=1.
6. n_rst=1 asserted during a data phase → after that edge: htrans=IDLE, busy=0, no rsp_valid. A new command after reset completes normally.
